// File: rtl/slice_word_assembler.sv
// Byte-to-word assembler: packs LANES bytes into one registered output word, with flush of partial words.
// Optional SLICE_ASM_SWAP_EN: first byte lands in the least significant lane instead of the most significant.
module slice_word_assembler #(
  parameter int LANES = 2
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [8*LANES-1:0] out_data,
  output logic               out_valid,
  output logic               out_partial,
  input  logic               out_ready
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      lane;
  logic [8*LANES-1:0] acc;
  logic [8*LANES-1:0] merged;
  logic               slot_free;
  logic               at_last;
  logic               accept;
  logic               complete;
  logic               do_flush;
  logic               load;

  always_comb begin
    slot_free = !out_valid | out_ready;
    at_last   = (cnt == LAST);
    // Stall only when this cycle would need the output register and it is still occupied.
    in_ready  = slot_free | !(at_last | (flush & (cnt != '0)));
    accept    = in_valid & in_ready;
    complete  = accept & at_last;
    do_flush  = flush & !complete & (accept | (cnt != '0)) & slot_free;
    load      = complete | do_flush;
`ifdef SLICE_ASM_SWAP_EN
    lane      = cnt;
`else
    lane      = LAST - cnt;
`endif
    merged    = acc;
    if (accept) begin
      merged[{lane, 3'b000} +: 8] = in_data;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt         <= '0;
      acc         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
    end else if (load) begin
      cnt         <= '0;
      acc         <= '0;
      out_data    <= merged;
      out_valid   <= 1'b1;
      out_partial <= do_flush;
    end else begin
      if (accept) begin
        cnt <= cnt + CW'(1);
      end
      acc <= merged;
      // out_data/out_partial keep their last value after the word drains.
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slice_word_assembler.sv
// Bench for slice_word_assembler: LANES=2 and LANES=4 instances checked against a byte-queue reference model.
// Honours SLICE_ASM_SWAP_EN for the expected lane order.
module tb_slice_word_assembler;

`ifdef SLICE_ASM_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic        CLK;
  logic        ASYNCRESETN;
  logic [7:0]  in_data [2];
  logic [1:0]  in_valid;
  logic [1:0]  flush;
  logic [1:0]  out_ready;
  logic        rdy2, rdy4, ov2, ov4, op2, op4;
  logic [15:0] od2;
  logic [31:0] od4;
  logic [1:0]  dut_rdy, dut_ov, dut_op;
  logic [31:0] dut_od [2];

  int vectors = 0;
  int miscompares = 0;

  slice_word_assembler #(.LANES(2)) u_dut2 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(rdy2), .flush(flush[0]), .out_data(od2), .out_valid(ov2),
    .out_partial(op2), .out_ready(out_ready[0]));

  slice_word_assembler #(.LANES(4)) u_dut4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(rdy4), .flush(flush[1]), .out_data(od4), .out_valid(ov4),
    .out_partial(op4), .out_ready(out_ready[1]));

  assign dut_rdy = {rdy4, rdy2};
  assign dut_ov  = {ov4, ov2};
  assign dut_op  = {op4, op2};
  always_comb begin
    dut_od[0] = {16'h0000, od2};
    dut_od[1] = od4;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: bytes collected so far plus the word currently offered downstream.
  logic [7:0]  mbuf [2][8];
  int          mcnt [2];
  logic [1:0]  mv, mp;
  logic [31:0] md [2];
  logic [1:0]  m_acc, m_full, m_fl;
  int          m_n [2];
  logic [31:0] m_w [2];

  function automatic int lanes(input int m);
    return (m == 0) ? 2 : 4;
  endfunction

  function automatic int lane_of(input int m, input int k);
    return SWAP ? k : lanes(m) - 1 - k;
  endfunction

  function automatic logic exp_rdy(input int m);
    return !(mv[m] & !out_ready[m] & ((mcnt[m] == lanes(m) - 1) | (flush[m] & (mcnt[m] != 0))));
  endfunction

  function automatic logic [31:0] pack(input int m, input logic addb);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < mcnt[m]; k++) w = w | (32'(mbuf[m][k]) << (8 * lane_of(m, k)));
    if (addb) w = w | (32'(in_data[m]) << (8 * lane_of(m, mcnt[m])));
    return w;
  endfunction

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      m_acc[m]  = in_valid[m] & exp_rdy(m);
      m_n[m]    = mcnt[m] + (m_acc[m] ? 1 : 0);
      m_w[m]    = pack(m, m_acc[m]);
      m_full[m] = (m_n[m] == lanes(m));
      m_fl[m]   = !m_full[m] & flush[m] & (m_n[m] != 0) & (!mv[m] | out_ready[m]);
    end
  end

  always @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int m = 0; m < 2; m++) begin
        mcnt[m] <= 0;
        mv[m]   <= 1'b0;
        mp[m]   <= 1'b0;
        md[m]   <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_acc[m]) mbuf[m][mcnt[m]] <= in_data[m];
        if (m_full[m] | m_fl[m]) begin
          mcnt[m] <= 0;
          mv[m]   <= 1'b1;
          md[m]   <= m_w[m];
          mp[m]   <= m_fl[m];
        end else begin
          mcnt[m] <= m_n[m];
          if (out_ready[m]) mv[m] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] w2(input logic [7:0] a, input logic [7:0] b);
    return SWAP ? {16'h0000, b, a} : {16'h0000, a, b};
  endfunction

  function automatic logic [31:0] w4(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return SWAP ? {d, c, b, a} : {a, b, c, d};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid  = 2'b00;
    flush     = 2'b00;
    out_ready = 2'b11;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    idle();
    #3;
    for (int m = 0; m < 2; m++) begin
      vectors++; if (dut_ov[m] !== 1'b0) begin miscompares++; $display("FAIL reset_ov[%0d]: got %b expected 0", m, dut_ov[m]); end
      vectors++; if (dut_od[m] !== 32'h0) begin miscompares++; $display("FAIL reset_od[%0d]: got %h expected 0", m, dut_od[m]); end
      vectors++; if (dut_op[m] !== 1'b0) begin miscompares++; $display("FAIL reset_op[%0d]: got %b expected 0", m, dut_op[m]); end
      vectors++; if (dut_rdy[m] !== 1'b1) begin miscompares++; $display("FAIL reset_rdy[%0d]: got %b expected 1", m, dut_rdy[m]); end
    end
    repeat (2) @(posedge CLK);
    #2;
    ASYNCRESETN = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      vectors++; if (dut_ov[m] !== 1'b0) begin miscompares++; $display("FAIL post_reset_ov[%0d]: got %b expected 0", m, dut_ov[m]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      in_data[0] = b[i]; in_data[1] = b[i];
      in_valid = 2'b11; out_ready = 2'b11; flush = 2'b00;
      #1;
      for (int m = 0; m < 2; m++) begin
        vectors++; if (dut_rdy[m] !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy[%0d] byte %0d: got %b expected 1", m, i, dut_rdy[m]); end
      end
      tick();
      vectors++; if (ov2 !== (i % 2 == 1)) begin miscompares++; $display("FAIL b2b_ov2 byte %0d: got %b expected %b", i, ov2, (i % 2 == 1)); end
      if (i % 2 == 1) begin
        vectors++; if (dut_od[0] !== w2(b[i-1], b[i])) begin miscompares++; $display("FAIL b2b_od2 byte %0d: got %h expected %h", i, dut_od[0], w2(b[i-1], b[i])); end
        vectors++; if (op2 !== 1'b0) begin miscompares++; $display("FAIL b2b_op2 byte %0d: got %b expected 0", i, op2); end
      end
      vectors++; if (ov4 !== (i == 3)) begin miscompares++; $display("FAIL b2b_ov4 byte %0d: got %b expected %b", i, ov4, (i == 3)); end
    end
    vectors++; if (od4 !== w4(b[0], b[1], b[2], b[3])) begin miscompares++; $display("FAIL b2b_od4: got %h expected %h", od4, w4(b[0], b[1], b[2], b[3])); end
    idle();
    tick();
    vectors++; if (dut_ov !== 2'b00) begin miscompares++; $display("FAIL b2b_drain: got %b expected 00", dut_ov); end
  endtask

  task automatic test_backpressure();
    idle();
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = 8'hAA; tick();
    in_data[0] = 8'hBB; tick();
    vectors++; if (ov2 !== 1'b1 || dut_od[0] !== w2(8'hAA, 8'hBB)) begin miscompares++; $display("FAIL bp_held: got ov %b od %h expected ov 1 od %h", ov2, dut_od[0], w2(8'hAA, 8'hBB)); end
    in_data[0] = 8'hCC; #1;
    vectors++; if (rdy2 !== 1'b1) begin miscompares++; $display("FAIL bp_rdy_cc: got %b expected 1", rdy2); end
    tick();
    in_data[0] = 8'hDD; #1;
    vectors++; if (rdy2 !== 1'b0) begin miscompares++; $display("FAIL bp_rdy_dd: got %b expected 0", rdy2); end
    tick();
    vectors++; if (ov2 !== 1'b1 || dut_od[0] !== w2(8'hAA, 8'hBB)) begin miscompares++; $display("FAIL bp_stable: got ov %b od %h expected ov 1 od %h", ov2, dut_od[0], w2(8'hAA, 8'hBB)); end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1; tick();
    vectors++; if (ov2 !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b expected 0", ov2); end
    in_valid[0] = 1'b1; #1;
    vectors++; if (rdy2 !== 1'b1) begin miscompares++; $display("FAIL bp_rdy_after: got %b expected 1", rdy2); end
    tick();
    vectors++; if (ov2 !== 1'b1 || dut_od[0] !== w2(8'hCC, 8'hDD)) begin miscompares++; $display("FAIL bp_ccdd: got ov %b od %h expected ov 1 od %h", ov2, dut_od[0], w2(8'hCC, 8'hDD)); end
    idle(); tick();
  endtask

  task automatic test_flush();
    idle();
    in_valid[1] = 1'b1;
    in_data[1] = 8'h11; tick();
    in_data[1] = 8'h22; tick();
    in_valid[1] = 1'b0; flush[1] = 1'b1; #1;
    vectors++; if (rdy4 !== 1'b1) begin miscompares++; $display("FAIL flush_rdy: got %b expected 1", rdy4); end
    tick();
    vectors++; if (ov4 !== 1'b1 || od4 !== w4(8'h11, 8'h22, 8'h00, 8'h00) || op4 !== 1'b1) begin miscompares++; $display("FAIL flush_word: got ov %b od %h op %b expected ov 1 od %h op 1", ov4, od4, op4, w4(8'h11, 8'h22, 8'h00, 8'h00)); end
    tick();
    vectors++; if (ov4 !== 1'b0 || op4 !== 1'b1) begin miscompares++; $display("FAIL flush_empty: got ov %b op %b expected ov 0 op 1", ov4, op4); end
    tick();
    vectors++; if (ov4 !== 1'b0) begin miscompares++; $display("FAIL flush_empty2: got ov %b expected 0", ov4); end
    idle(); tick();
  endtask

  task automatic test_flush_last_byte();
    idle();
    in_valid[0] = 1'b1;
    in_data[0] = 8'h01; tick();
    in_data[0] = 8'h02; flush[0] = 1'b1; tick();
    vectors++; if (ov2 !== 1'b1 || dut_od[0] !== w2(8'h01, 8'h02) || op2 !== 1'b0) begin miscompares++; $display("FAIL flush_last: got ov %b od %h op %b expected ov 1 od %h op 0", ov2, dut_od[0], op2, w2(8'h01, 8'h02)); end
    in_valid[0] = 1'b0; tick();
    vectors++; if (ov2 !== 1'b0 || op2 !== 1'b0) begin miscompares++; $display("FAIL flush_last_after: got ov %b op %b expected ov 0 op 0", ov2, op2); end
    idle(); tick();
  endtask

  task automatic test_reset_mid();
    idle();
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = 8'h30; tick();
    in_data[0] = 8'h31; tick();
    in_data[0] = 8'h55; tick();
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    vectors++; if (ov2 !== 1'b0 || od2 !== 16'h0000 || op2 !== 1'b0 || rdy2 !== 1'b1) begin miscompares++; $display("FAIL reset_mid: got ov %b od %h op %b rdy %b expected ov 0 od 0000 op 0 rdy 1", ov2, od2, op2, rdy2); end
    in_valid[0] = 1'b0;
    tick();
    ASYNCRESETN = 1'b1;
    out_ready[0] = 1'b1; in_valid[0] = 1'b1;
    in_data[0] = 8'h66; tick();
    in_data[0] = 8'h77; tick();
    vectors++; if (ov2 !== 1'b1 || dut_od[0] !== w2(8'h66, 8'h77)) begin miscompares++; $display("FAIL reset_mid_word: got ov %b od %h expected ov 1 od %h", ov2, dut_od[0], w2(8'h66, 8'h77)); end
    idle(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        in_valid[m]  = ($urandom_range(0, 9) < 7);
        flush[m]     = ($urandom_range(0, 9) < 2);
        out_ready[m] = ($urandom_range(0, 9) < 6);
        in_data[m]   = 8'($urandom);
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        vectors++; if (dut_rdy[m] !== exp_rdy(m)) begin miscompares++; $display("FAIL rnd_rdy[%0d] cyc %0d: got %b expected %b", m, i, dut_rdy[m], exp_rdy(m)); end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        vectors++; if (dut_ov[m] !== mv[m]) begin miscompares++; $display("FAIL rnd_ov[%0d] cyc %0d: got %b expected %b", m, i, dut_ov[m], mv[m]); end
        vectors++; if (dut_od[m] !== md[m]) begin miscompares++; $display("FAIL rnd_od[%0d] cyc %0d: got %h expected %h", m, i, dut_od[m], md[m]); end
        vectors++; if (dut_op[m] !== mp[m]) begin miscompares++; $display("FAIL rnd_op[%0d] cyc %0d: got %b expected %b", m, i, dut_op[m], mp[m]); end
      end
    end
    idle(); tick();
  endtask

  initial begin
    in_data[0] = 8'h00;
    in_data[1] = 8'h00;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_last_byte();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
